led_pattern_scheduler: RTL and testbench
========================================

Name: led_pattern_scheduler

Overview:
- Shares the eight board LEDs (D1-D8) between up to four requesters, e.g. game-event sources such as "player hit" or "wave cleared".
- Each requester asks to show one 8-bit pattern for a number of display ticks. The block arbitrates round-robin, shows the winner's pattern, then inserts one blank tick.
- When no request is pending, it falls back to the half-second all-LED blink.
- Owns the 12 MHz prescaler that produces the display tick.

Parameters:
- TICK_DIV, 6000000, clk cycles per display tick (0.5 s at 12 MHz); must be >= 2.
- DUR_W, 4, width of each requester's duration field, in ticks.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst_n  input  1  reset; asynchronous assert, active-low.
- req  input  4  level request per requester; bit i = requester i.
- req_pattern  input  32  packed patterns; bits [8i+7:8i] = requester i.
- req_dur  input  4*DUR_W  packed durations in ticks; field i = requester i.
- grant  output  4  one-hot, one-cycle pulse; requester whose pattern was latched.
- busy  output  1  high in SHOW or GAP.
- active_id  output  2  index of the last granted requester.
- leds  output  8  LED drive, 1 = lit; bit 0 = D1.

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE; prescaler = 0; blink = 0; leds = 8'h00.
  - grant = 0; busy = 0; active_id = 0.
  - last_grant = 3, so requester 0 has first priority after reset.
- Prescaler:
  - Free-running counter, 0..TICK_DIV-1.
  - tick is a one-cycle internal pulse when count == TICK_DIV-1; the counter wraps to 0 on the same edge.
  - Never reset except by rst_n.
  - The first tick in SHOW may be partial. The visible duration is therefore between (dur-1)*TICK_DIV+1 and dur*TICK_DIV cycles.
- blink toggles on every tick in all states and is only displayed in IDLE.
- State machine: IDLE, SHOW, GAP.
- IDLE:
  - leds = {8{blink}}.
  - On an edge where req != 0, select the winner: the first set bit searching upward from last_grant+1, modulo 4.
  - On that edge: grant[winner] <= 1, latch pat <= pattern field, latch rem <= dur field (dur 0 is treated as 1), active_id <= winner, last_grant <= winner, busy <= 1, state <= SHOW.
  - Latency: req seen at edge N gives grant high and leds = pattern during cycle N..N+1.
- SHOW:
  - leds = pat; grant returns to 0 after one cycle.
  - On tick: if rem == 1, go to GAP; else rem <= rem - 1.
  - Requests and input changes are ignored; pattern and duration are already latched.
- GAP:
  - leds = 8'h00.
  - On the next tick, go to IDLE and set busy <= 0.
  - Arbitration can occur on the first edge in IDLE; the blink pattern is then not visible.
- Handshake:
  - req is level-sensitive; grant is the acknowledge.
  - A requester holding req after its grant is re-arbitrated after GAP. Round-robin ensures the others are served first.
  - A requester dropping req before it is granted loses its slot; there is no queueing.
- Simultaneous events:
  - tick on the same edge as arbitration in IDLE: arbitration wins, and that tick does not count toward rem.
  - Several req bits set: only one grant per arbitration.
- Widths:
  - rem is DUR_W bits; the maximum duration is 2^DUR_W - 1 ticks.
  - Prescaler width is clog2(TICK_DIV).
- Reset mid-operation: all state returns to reset values immediately and asynchronously; leds go dark with no glitch to any pattern.

Test Plan:
Benches use TICK_DIV=4, DUR_W=4.
- Reset/idle: rst_n low then released, req=0 -> leds 00 until the first tick (cycle 4), then FF and 00 alternating every 4 cycles; busy=0; grant=0.
- Single request: req=0001, pattern0=A5, dur0=3 -> grant=0001 for exactly one cycle on the next edge; leds=A5 with busy=1; SHOW exits on the 3rd tick; leds=00 for one full tick (4 cycles); then IDLE with busy=0.
- Round-robin: req=1111 held with distinct patterns 01/02/04/08, all dur=1 -> grants in order 0001, 0010, 0100, 1000, 0001; active_id = 0,1,2,3,0; a GAP tick of 00 between each.
- dur=0 and max: dur0=0 -> pattern shown for one tick; dur0=F -> pattern shown across 15 ticks.
- Input change during SHOW: pattern0 changed from 3C to FF and req1 asserted mid-SHOW -> leds stay 3C; requester 1 is granted only after GAP.
- Async reset mid-SHOW: rst_n pulled low between edges -> leds=00, busy=0, grant=0 immediately without waiting for clk; after release, requester 0 has priority over 1 when req=0011.

Source files
------------

// File: rtl/led_pattern_scheduler_if.sv
// Request/grant bundle between game-event requesters and the LED scheduler.
// The requester side drives req/pattern/duration; the scheduler answers with grant/busy/active_id.
interface led_pattern_scheduler_if #(
  parameter int DUR_W = 4
);
  logic [3:0]         req;
  logic [31:0]        req_pattern;
  logic [4*DUR_W-1:0] req_dur;
  logic [3:0]         grant;
  logic               busy;
  logic [1:0]         active_id;

  modport master (
    output req, req_pattern, req_dur,
    input  grant, busy, active_id
  );

  modport slave (
    input  req, req_pattern, req_dur,
    output grant, busy, active_id
  );
endinterface

// File: rtl/led_pattern_scheduler.sv
// Round-robin scheduler sharing the eight board LEDs between four pattern requesters,
// with a display-tick prescaler and an idle all-LED blink.
module led_pattern_scheduler #(
  parameter int TICK_DIV = 6000000,
  parameter int DUR_W    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  led_pattern_scheduler_if.slave  bus,
  output logic [7:0]              leds
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic               blink;
  logic [7:0]         pat, pat_nxt;
  logic [DUR_W-1:0]   rem, rem_nxt;
  logic [1:0]         last_grant, last_grant_nxt;
  logic [1:0]         active_id_nxt;
  logic [3:0]         grant_nxt;
  logic               busy_nxt;

  logic               found;
  logic [1:0]         winner;
  logic [1:0]         cand;
  logic [7:0]         win_pat;
  logic [DUR_W-1:0]   win_dur;

  // Free-running display-tick prescaler; blink flips on every tick regardless of state.
  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  // NOTE: sequential state is written with non-blocking (<=) so every register
  // samples pre-edge values; blocking (=) belongs only in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) blink <= ~blink;
    end
  end

  // Round-robin search: first set req bit strictly after last_grant, wrapping to it last.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    cand   = last_grant;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign win_pat = bus.req_pattern[winner*8 +: 8];
  assign win_dur = bus.req_dur[winner*DUR_W +: DUR_W];

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    pat_nxt        = pat;
    rem_nxt        = rem;
    last_grant_nxt = last_grant;
    active_id_nxt  = bus.active_id;
    grant_nxt      = 4'b0000;
    busy_nxt       = bus.busy;
    leds           = 8'h00;

    unique case (state)
      IDLE: begin
        leds = {8{blink}};
        // Arbitration takes precedence over a coincident tick; that tick is not counted.
        if (found) begin
          grant_nxt      = 4'b0001 << winner;
          pat_nxt        = win_pat;
          rem_nxt        = (win_dur == '0) ? DUR_W'(1) : win_dur;
          active_id_nxt  = winner;
          last_grant_nxt = winner;
          busy_nxt       = 1'b1;
          state_nxt      = SHOW;
        end
      end
      SHOW: begin
        leds = pat;
        if (tick) begin
          if (rem == DUR_W'(1)) state_nxt = GAP;
          else                  rem_nxt   = rem - DUR_W'(1);
        end
      end
      GAP: begin
        leds = 8'h00;
        if (tick) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last_grant resets to 3 so requester 0 is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pat           <= 8'h00;
      rem           <= '0;
      last_grant    <= 2'd3;
      bus.active_id <= 2'd0;
      bus.grant     <= 4'b0000;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_nxt;
      pat           <= pat_nxt;
      rem           <= rem_nxt;
      last_grant    <= last_grant_nxt;
      bus.active_id <= active_id_nxt;
      bus.grant     <= grant_nxt;
      bus.busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed bench for led_pattern_scheduler with TICK_DIV=4, DUR_W=4.
// Each test resets first so edge k after release has a known prescaler phase (ticks land on edges 4,8,...).
module tb_led_pattern_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] leds;
  int         checks;
  int         failures;

  led_pattern_scheduler_if #(.DUR_W(4)) bus ();

  led_pattern_scheduler #(
    .TICK_DIV (4),
    .DUR_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .leds  (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset for two cycles and release between edges; the next posedge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_leds;
    bus.req = 4'b0000;
    bus.req_pattern = 32'h0;
    bus.req_dur = 16'h0;
    do_reset();
    checks++;
    if (leds !== 8'h00 || bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.active_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_state leds=%h busy=%b grant=%b id=%0d required 00/0/0000/0",
               leds, bus.busy, bus.grant, bus.active_id);
    end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_leds = ((k / 4) % 2 == 1) ? 8'hFF : 8'h00;
      checks++;
      if (leds !== exp_leds || bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
        failures++;
        $display("FAIL idle_blink k=%0d leds=%h busy=%b grant=%b required %h/0/0000",
                 k, leds, bus.busy, bus.grant, exp_leds);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_leds;
    logic       exp_busy;
    logic [3:0] exp_grant;
    bus.req = 4'b0001;
    bus.req_pattern = 32'h000000A5;
    bus.req_dur = 16'h0003;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k < 12)      exp_leds = 8'hA5;
      else if (k < 16) exp_leds = 8'h00;
      else             exp_leds = ((k / 4) % 2 == 1) ? 8'hFF : 8'h00;
      exp_busy  = (k < 16);
      exp_grant = (k == 1) ? 4'b0001 : 4'b0000;
      checks++;
      if (leds !== exp_leds || bus.busy !== exp_busy || bus.grant !== exp_grant || bus.active_id !== 2'd0) begin
        failures++;
        $display("FAIL single k=%0d leds=%h busy=%b grant=%b id=%0d required %h/%b/%b/0",
                 k, leds, bus.busy, bus.grant, bus.active_id, exp_leds, exp_busy, exp_grant);
      end
      if (k == 1) bus.req = 4'b0000;
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_leds;
    logic       exp_busy;
    logic [3:0] exp_grant;
    logic [1:0] exp_id;
    int         p;
    bus.req = 4'b1111;
    bus.req_pattern = 32'h08040201;
    bus.req_dur = 16'h1111;
    do_reset();
    for (int k = 1; k <= 33; k++) begin
      step();
      p         = (k - 1) % 8;
      exp_id    = 2'(((k - 1) / 8) % 4);
      exp_leds  = (p < 3) ? (8'h01 << exp_id) : 8'h00;
      exp_busy  = (p < 7);
      exp_grant = (p == 0) ? (4'b0001 << exp_id) : 4'b0000;
      checks++;
      if (leds !== exp_leds || bus.busy !== exp_busy || bus.grant !== exp_grant || bus.active_id !== exp_id) begin
        failures++;
        $display("FAIL round_robin k=%0d leds=%h busy=%b grant=%b id=%0d required %h/%b/%b/%0d",
                 k, leds, bus.busy, bus.grant, bus.active_id, exp_leds, exp_busy, exp_grant, exp_id);
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_dur_limits();
    logic [7:0] exp_leds;
    logic       exp_busy;
    bus.req = 4'b0001;
    bus.req_pattern = 32'h0000005A;
    bus.req_dur = 16'h0000;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_leds = (k < 4) ? 8'h5A : 8'h00;
      exp_busy = (k < 8);
      checks++;
      if (leds !== exp_leds || bus.busy !== exp_busy) begin
        failures++;
        $display("FAIL dur_zero k=%0d leds=%h busy=%b required %h/%b", k, leds, bus.busy, exp_leds, exp_busy);
      end
      if (k == 1) bus.req = 4'b0000;
    end

    bus.req = 4'b0001;
    bus.req_pattern = 32'h000000C3;
    bus.req_dur = 16'h000F;
    do_reset();
    for (int k = 1; k <= 64; k++) begin
      step();
      exp_leds = (k < 60) ? 8'hC3 : 8'h00;
      exp_busy = (k < 64);
      checks++;
      if (leds !== exp_leds || bus.busy !== exp_busy) begin
        failures++;
        $display("FAIL dur_max k=%0d leds=%h busy=%b required %h/%b", k, leds, bus.busy, exp_leds, exp_busy);
      end
      if (k == 1) bus.req = 4'b0000;
    end
  endtask

  task automatic test_input_change();
    logic [7:0] exp_leds;
    logic       exp_busy;
    logic [3:0] exp_grant;
    logic [1:0] exp_id;
    bus.req = 4'b0001;
    bus.req_pattern = 32'h0000003C;
    bus.req_dur = 16'h0002;
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k < 8)       exp_leds = 8'h3C;
      else if (k < 12) exp_leds = 8'h00;
      else if (k == 12) exp_leds = 8'hFF;
      else             exp_leds = 8'h77;
      exp_busy  = (k != 12);
      exp_grant = (k == 1) ? 4'b0001 : (k == 13) ? 4'b0010 : 4'b0000;
      exp_id    = (k == 13) ? 2'd1 : 2'd0;
      checks++;
      if (leds !== exp_leds || bus.busy !== exp_busy || bus.grant !== exp_grant || bus.active_id !== exp_id) begin
        failures++;
        $display("FAIL input_change k=%0d leds=%h busy=%b grant=%b id=%0d required %h/%b/%b/%0d",
                 k, leds, bus.busy, bus.grant, bus.active_id, exp_leds, exp_busy, exp_grant, exp_id);
      end
      if (k == 2) begin
        bus.req = 4'b0011;
        bus.req_pattern = 32'h000077FF;
        bus.req_dur = 16'h0012;
      end
    end
    bus.req = 4'b0000;
  endtask

  task automatic test_async_reset();
    bus.req = 4'b0001;
    bus.req_pattern = 32'h00000099;
    bus.req_dur = 16'h0005;
    do_reset();
    @(posedge clk);
    #2;
    checks++;
    if (leds !== 8'h99 || bus.grant !== 4'b0001 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_show leds=%h grant=%b busy=%b required 99/0001/1", leds, bus.grant, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (leds !== 8'h00 || bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.active_id !== 2'd0) begin
      failures++;
      $display("FAIL async_reset leds=%h busy=%b grant=%b id=%0d required 00/0/0000/0",
               leds, bus.busy, bus.grant, bus.active_id);
    end
    bus.req = 4'b0011;
    bus.req_pattern = 32'h00002211;
    bus.req_dur = 16'h0011;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.grant !== 4'b0001 || bus.active_id !== 2'd0 || leds !== 8'h11) begin
      failures++;
      $display("FAIL post_reset_priority grant=%b id=%0d leds=%h required 0001/0/11",
               bus.grant, bus.active_id, leds);
    end
    bus.req = 4'b0000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.req_pattern = 32'h0;
    bus.req_dur = 16'h0;
    test_reset();
    test_single();
    test_round_robin();
    test_dur_limits();
    test_input_change();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
